// File: rtl/dm_bus_pkg.sv
// Shared types and widths for the data-memory bus responder.
// Holds the FSM state encoding, counter width and bus widths used by every file of the slice.
package dm_bus_pkg;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Replace the enabled bytes of a word; disabled bytes keep their old value.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_bus_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory responder (slave).
// req/we/addr/be/wdata come from the initiator; rdata/ready/err are the response.
interface dm_bus_if;
  import dm_bus_pkg::*;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ready, err
  );

endinterface

// File: rtl/dm_word_ram.sv
// Word-organised RAM: synchronous per-byte write, asynchronous read by word index.
// The array has no reset; the parent registers the read data for output timing.
module dm_word_ram
  import dm_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [BE_W-1:0]       be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dm_bus_responder.sv
// Data-memory target for the pipeline's load/store bus: latches a request, waits
// WAIT_CYCLES, then answers with a one-cycle registered ready/err/rdata pulse.
//
// state | meaning
// IDLE  | waiting for req; samples and latches the access
// WAIT  | down-counting wait states; req dropped here aborts the access
// RESP  | ready high for this single cycle; req is not sampled
module dm_bus_responder
  import dm_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  dm_bus_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(WAIT_CYCLES);
  localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [BE_W-1:0]   lat_be;
  logic [DATA_W-1:0] lat_wdata;
  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [BE_W-1:0]   acc_be;
  logic [DATA_W-1:0] acc_wdata;
  logic [31:0]       acc_off;
  logic [31:ADDR_WIDTH+2] off_hi;
  logic [ADDR_WIDTH-1:0]  acc_idx;
  logic [1:0]        off_lo;
  logic              acc_err;
  logic              fire;
  logic              wr_en;
  logic [DATA_W-1:0] ram_q;

  // A zero-wait access completes straight out of IDLE, so it uses the live bus
  // fields; otherwise the latched copies are authoritative.
  assign acc_we    = (state == IDLE) ? bus.we    : lat_we;
  assign acc_addr  = (state == IDLE) ? bus.addr  : lat_addr;
  assign acc_be    = (state == IDLE) ? bus.be    : lat_be;
  assign acc_wdata = (state == IDLE) ? bus.wdata : lat_wdata;

  // Unsigned wrap makes addr < BASE_ADDR land in off_hi and fail the range test.
  assign acc_off = acc_addr - BASE_ADDR;
  assign {off_hi, acc_idx, off_lo} = acc_off;

  // off_lo only differs from addr[1:0] if BASE_ADDR itself is misaligned.
  assign acc_err = (acc_addr[1:0] != 2'b00) || (off_lo != 2'b00) || (off_hi != '0);

  assign fire = !reset && bus.req &&
                (((state == IDLE) && ZERO_WAIT) ||
                 ((state == WAIT) && (cnt == CNT_W'(1))));

  assign wr_en = fire && acc_we && !acc_err;

  dm_word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .wr_en (wr_en),
    .idx   (acc_idx),
    .be    (acc_be),
    .wdata (acc_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;

      case (state)
        IDLE: begin
          if (bus.req) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_be    <= bus.be;
            lat_wdata <= bus.wdata;
            cnt       <= WAIT_LD;
            state     <= ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!bus.req) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fire) begin
        ready_q <= 1'b1;
        err_q   <= acc_err;
        rdata_q <= (acc_we || acc_err) ? '0 : ram_q;
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dm_bus_responder.sv
// Scoreboard bench for dm_bus_responder: five instances with different wait states and
// base addresses, driven from one stimulus process and checked by a separate monitor.
module tb_dm_bus_responder;
  import dm_bus_pkg::*;

  localparam int NDUT = 5;
  localparam int AW   = 10;

  function automatic int wc_of(input int g);
    case (g)
      0:       return 2;
      1:       return 0;
      2:       return 1;
      3:       return 5;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int g);
    return (g == 2) ? 32'h0000_4000 : 32'h0000_0000;
  endfunction

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  int          sel;
  int          cyc;

  logic        rdy_v   [NDUT];
  logic        err_v   [NDUT];
  logic [31:0] rdata_v [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gd
    dm_bus_if bus ();
    assign bus.req   = req && (sel == g);
    assign bus.we    = we;
    assign bus.addr  = addr;
    assign bus.be    = be;
    assign bus.wdata = wdata;

    dm_bus_responder #(
      .ADDR_WIDTH  (AW),
      .WAIT_CYCLES (wc_of(g)),
      .BASE_ADDR   (base_of(g))
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign rdy_v[g]   = bus.ready;
    assign err_v[g]   = bus.err;
    assign rdata_v[g] = bus.rdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: memory contents per instance, keyed by instance*4096 + word.
  logic [31:0] mdl [int];

  typedef struct {
    int          dut;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sbq [$];

  function automatic logic model_err(input int g, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(g);
    return (a[1:0] != 2'b00) || (off >= 32'h0000_1000);
  endfunction

  task automatic model_apply(input int g, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d,
                             output logic e, output logic [31:0] r);
    logic [31:0] off;
    int          key;
    logic [31:0] old;
    e = model_err(g, a);
    r = 32'h0;
    if (!e) begin
      off = a - base_of(g);
      key = g * 4096 + int'(off[11:2]);
      old = mdl.exists(key) ? mdl[key] : 32'h0;
      if (w) mdl[key] = merge_bytes(old, d, b);
      else   r = old;
    end
  endtask

  // Called on a negedge. b2b=1 means the target is in its RESP cycle, so the
  // request is sampled one cycle later than from IDLE. Returns on the ready negedge.
  task automatic access(input int g, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input bit b2b, input bit scram);
    int          n;
    int          tmo;
    logic        e;
    logic [31:0] r;
    exp_t        x;
    sel   = g;
    req   = 1'b1;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
    n = b2b ? cyc + 1 : cyc;
    model_apply(g, w, a, b, d, e, r);
    x.dut   = g;
    x.err   = e;
    x.rdata = r;
    x.due   = n + wc_of(g) + 1;
    sbq.push_back(x);
    tmo = 0;
    @(negedge clk);
    while (!rdy_v[g] && tmo < 40) begin
      if (scram && cyc > n) begin
        we    = 1'($urandom);
        addr  = $urandom;
        be    = 4'($urandom);
        wdata = $urandom;
      end
      tmo++;
      @(negedge clk);
    end
    if (!rdy_v[g]) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout dut%0d addr=%h: no ready within %0d cycles, required by cycle %0d",
               g, a, tmo, x.due);
    end
  endtask

  task automatic drop();
    req   = 1'b0;
    we    = 1'($urandom);
    addr  = $urandom;
    be    = 4'($urandom);
    wdata = $urandom;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every ready pulse and checks idle outputs otherwise.
  logic prev_rdy [NDUT];
  initial begin
    exp_t x;
    for (int g = 0; g < NDUT; g++) prev_rdy[g] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (rdy_v[g]) begin
          compared++;
          if (prev_rdy[g]) begin
            mismatched++;
            $display("FAIL ready_consecutive dut%0d cycle %0d: ready high two cycles in a row", g, cyc);
          end
          if (sbq.size() == 0 || sbq[0].dut != g) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_ready dut%0d cycle %0d: got ready=1, required none", g, cyc);
          end else begin
            x = sbq.pop_front();
            compared += 3;
            if (cyc != x.due) begin
              mismatched++;
              $display("FAIL latency dut%0d: ready at cycle %0d, required %0d", g, cyc, x.due);
            end
            if (err_v[g] !== x.err) begin
              mismatched++;
              $display("FAIL err dut%0d cycle %0d: got %b, required %b", g, cyc, err_v[g], x.err);
            end
            if (rdata_v[g] !== x.rdata) begin
              mismatched++;
              $display("FAIL rdata dut%0d cycle %0d: got %h, required %h", g, cyc, rdata_v[g], x.rdata);
            end
          end
        end else begin
          compared++;
          if (rdata_v[g] !== 32'h0 || err_v[g] !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_outputs dut%0d cycle %0d: got rdata=%h err=%b, required 0/0",
                     g, cyc, rdata_v[g], err_v[g]);
          end
        end
        prev_rdy[g] = rdy_v[g];
      end
      if (sbq.size() > 0 && cyc > sbq[0].due) begin
        x = sbq.pop_front();
        compared++;
        mismatched++;
        $display("FAIL missing_ready dut%0d: no ready by cycle %0d, required at %0d", x.dut, cyc, x.due);
      end
    end
  end

  initial begin
    int          c0;
    int          kind;
    int          widx;
    logic [31:0] a;
    logic [31:0] bs;
    bit          b2b;

    reset = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    be    = 4'h0;
    wdata = 32'h0;
    sel   = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      compared++;
      if (rdy_v[g] !== 1'b0 || err_v[g] !== 1'b0 || rdata_v[g] !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_state dut%0d: got ready=%b err=%b rdata=%h, required 0/0/0",
                 g, rdy_v[g], err_v[g], rdata_v[g]);
      end
    end
    reset = 1'b0;
    @(negedge clk);

    // Store then load on the two-wait-state instance.
    access(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0); drop();
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);         drop();

    // Byte enables and the be=0 no-op.
    access(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, 1'b0); drop();
    access(0, 1'b1, 32'h20, 4'h5, 32'hAABB_CCDD, 1'b0, 1'b0); drop();
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0);         drop();
    access(0, 1'b1, 32'h20, 4'h0, 32'h5555_5555, 1'b0, 1'b0); drop();
    access(0, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0);         drop();

    // Misaligned and out-of-range accesses.
    access(0, 1'b0, 32'h22, 4'hF, 32'h0, 1'b0, 1'b0);         drop();
    access(0, 1'b1, 32'h0, 4'hF, 32'h0102_0304, 1'b0, 1'b0);  drop();
    access(0, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0); drop();
    access(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);          drop();

    // Zero wait states with req held high across back-to-back accesses.
    access(1, 1'b1, 32'h0, 4'hF, 32'hCAFE_0000, 1'b0, 1'b0);
    access(1, 1'b1, 32'h4, 4'hF, 32'hCAFE_0004, 1'b1, 1'b0);
    access(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0);
    access(1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1, 1'b0);
    drop();

    // req dropped during WAIT: no response, word unchanged.
    sel = 0; req = 1'b1; we = 1'b1; addr = 32'h10; be = 4'hF; wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0); drop();

    // Reset in the cycle before RESP on a store.
    sel = 0; req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'h0BAD_F00D;
    c0 = cyc;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    compared++;
    if (rdy_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_abort_ready cycle %0d (req at %0d): got ready=%b, required 0", cyc, c0, rdy_v[0]);
    end
    reset = 1'b0;
    @(negedge clk);
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0);         drop();
    access(0, 1'b1, 32'h30, 4'hF, 32'h1357_9BDF, 1'b0, 1'b0); drop();
    access(0, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 1'b0);         drop();

    // Randomised traffic with scrambled inputs during WAIT on every instance.
    for (int g = 0; g < NDUT; g++) begin
      bs = base_of(g);
      for (int w = 0; w < 16; w++) begin
        access(g, 1'b1, bs + 32'(4 * w), 4'hF, $urandom, 1'b0, 1'b1);
        drop();
      end
      for (int k = 0; k < 30; k++) begin
        kind = $urandom_range(0, 9);
        widx = $urandom_range(0, 15);
        a = bs + 32'(4 * widx);
        if (kind == 0)      a = a + 32'($urandom_range(1, 3));
        else if (kind == 1) a = bs + 32'h1000 + 32'(4 * $urandom_range(0, 3));
        else if (kind == 2) a = bs - 32'd4;
        b2b = (k != 0) && ($urandom_range(0, 1) == 1);
        if (!b2b && k != 0) drop();
        access(g, 1'($urandom), a, 4'($urandom), $urandom, b2b, 1'b1);
      end
      drop();
    end

    for (int t = 0; t < 100 && sbq.size() > 0; t++) @(negedge clk);
    if (sbq.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dm_bus_responder.md
Name: dm_bus_responder

Overview:
- Data-memory responder on the CPU's load/store bus. The mips pipeline's MEM stage is the initiator; this block is the target end.
- Word-organised RAM with byte-enable writes and a configurable number of wait states.
- Range and alignment checking, with an error response.
- Gives the pipeline real stall behaviour to exercise, instead of a zero-latency array.

Parameters:
- ADDR_WIDTH, 10, number of word-address bits; depth is 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2, idle cycles inserted between accepting a request and responding; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  request valid; held by the initiator until ready.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- be  in  4  byte enables for stores; be[0] selects wdata[7:0]; ignored for loads.
- wdata  in  32  store data.
- rdata  out  32  load data; valid only while ready=1, otherwise 0.
- ready  out  1  one-cycle response pulse.
- err  out  1  qualified by ready; 1 = access rejected.

Behaviour:
- Reset:
  - Forces IDLE.
  - ready=0, err=0, rdata=0, wait counter=0.
  - RAM contents are not cleared.
- States:
  - IDLE: if req=1, latch we/addr/be/wdata, load counter with WAIT_CYCLES, then go to WAIT (or to RESP if WAIT_CYCLES=0).
  - WAIT: decrement the counter each cycle; at 0 go to RESP.
  - RESP: ready=1 for exactly one cycle; next state is IDLE.
- Latency:
  - req is sampled in cycle N; ready is high in cycle N+WAIT_CYCLES+1.
  - With WAIT_CYCLES=0, ready is high in cycle N+1.
- Outputs in RESP are registered; none are combinational from inputs.
- Error detection:
  - Misaligned access (addr[1:0]!=0) gives err=1.
  - Out of range (addr-BASE_ADDR >= 4*2**ADDR_WIDTH, with unsigned 32-bit subtraction so that addr<BASE_ADDR also fails) gives err=1.
  - On error: no RAM write, rdata=0.
- Store:
  - The RAM write happens at the clock edge that enters RESP, so a load accepted after ready sees the new data.
  - Only the enabled bytes are updated.
  - be=4'b0000 is a legal no-op: err=0, ready still pulses.
- Load:
  - rdata = the full 32-bit word in the RESP cycle.
  - be is ignored.
- Back-to-back:
  - In the RESP cycle, req is not sampled as a new request.
  - If req is still high in the cycle after ready (IDLE), it is a new request. The initiator must drop req or present the next access.
  - Maximum throughput: one access per WAIT_CYCLES+2 cycles.
- req dropped while in WAIT:
  - This is a protocol violation; the responder aborts.
  - Return to IDLE with no write and no ready pulse.
- Inputs changing during WAIT are ignored; the latched copies are used.
- reset asserted mid-transaction (WAIT or RESP):
  - The access is abandoned and the write is suppressed.
  - ready=0 in the following cycle.
- The word index is (addr-BASE_ADDR)[ADDR_WIDTH+1:2]; there is no wrap-around, because out-of-range addresses always err.

Decomposition:
- Shared package dm_bus_pkg:
  - State enum: IDLE, WAIT, RESP.
  - Counter width constant (4).
  - Bus width constants: DATA_W=32, BE_W=4.
- Sub-module dm_word_ram:
  - Synchronous write, per-byte enables.
  - Asynchronous read by word index; the registered rdata in the parent provides the output timing.
  - No reset on the array.
- Parent contains the FSM, wait counter, request latch and address checking.

Test Plan:
1. Store then load, WAIT_CYCLES=2, BASE_ADDR=0: write addr=0x10, be=4'hF, wdata=0xDEADBEEF.
   - ready at N+3 with err=0.
   - A following load of 0x10 returns rdata=0xDEADBEEF exactly in its ready cycle; rdata=0 in all other cycles.
2. Byte enables: word 0x20 holds 0x11223344; store be=4'b0101, wdata=0xAABBCCDD.
   - A subsequent load returns 0x11BB33DD.
   - A store with be=0 leaves the word unchanged, ready=1, err=0.
3. Errors:
   - Load of addr=0x22 (misaligned) gives ready=1, err=1, rdata=0.
   - Store of addr=0x1000 with ADDR_WIDTH=10 (out of range) gives err=1; reading word 0 afterwards shows it unchanged.
4. WAIT_CYCLES=0 with req held high continuously: ready pulses at cycles N+1, N+3, N+5, and is never high on two consecutive cycles.
5. Abort paths:
   - req deasserted during WAIT: no ready pulse, target word unchanged.
   - reset asserted in the cycle before RESP on a store: ready=0 afterwards, target word unchanged, next request serviced normally.
6. Latency sweep over WAIT_CYCLES in {0,1,5,15}: ready arrives exactly WAIT_CYCLES+1 cycles after req is sampled, and the inputs scrambled during WAIT do not affect the result.
